// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit
// Iterative unsigned multiply/divide unit that owns the HI/LO register pair.
// MULTU uses a shift-add loop and DIVU a restoring division loop. Both take
// exactly WIDTH cycles. MFHI/MFLO reads are served through lh_data. MTHI/MTLO
// writes come from op_a.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   start, is_div   request a new MULTU (is_div=0) or DIVU (is_div=1)
//   op_a, op_b      Rs / Rt operands (multiplicand/dividend, multiplier/divisor)
//   lh_sel          read select: 01 = LO, 10 = HI, otherwise none (lh_data = 0)
//   wr_hi, wr_lo    MTHI / MTLO write enables, data taken from op_a
//   lh_data         selected HI/LO value (combinational)
//   hi, lo          HI / LO registers
//   busy            operation in flight
//   done            one-cycle pulse after HI/LO were updated by mul/div
//   stall           hold the pipeline (combinational)
module hilo_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [1:0]       lh_sel,
  input  logic             wr_hi,
  input  logic             wr_lo,
  output logic [WIDTH-1:0] lh_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // MUL: {running high half, remaining multiplier bits}.
  // DIV: low half holds the dividend, which shifts out as quotient bits shift in.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;   // multiplicand (MUL) or divisor (DIV)
  logic [WIDTH-1:0]   rem_q, rem_d;   // partial remainder, always < 2^WIDTH
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               last_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [2*WIDTH-1:0] mul_next_s;
  logic [WIDTH:0]     div_shift_s;
  logic               div_ge_s;
  logic [WIDTH-1:0]   div_rem_s;
  logic [WIDTH-1:0]   div_quot_s;

  // One iteration of the shift-add multiply and of the restoring divide.
  always_comb begin
    last_s = (cnt_q == CNT_W'(WIDTH - 1));
    // The carry out of the add lands in the top bit after the right shift.
    if (acc_q[0]) begin
      mul_sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
    end else begin
      mul_sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    end
    mul_next_s  = {mul_sum_s, acc_q[WIDTH-1:1]};
    // The remainder plus the next dividend bit needs WIDTH+1 bits.
    div_shift_s = {rem_q, acc_q[WIDTH-1]};
    div_ge_s    = (div_shift_s >= {1'b0, opb_q});
    // When the subtraction succeeds, the true result is below the divisor.
    // A WIDTH-bit modular subtract is therefore exact.
    if (div_ge_s) begin
      div_rem_s  = div_shift_s[WIDTH-1:0] - opb_q;
      div_quot_s = {acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_rem_s  = div_shift_s[WIDTH-1:0];
      div_quot_s = {acc_q[WIDTH-2:0], 1'b0};
    end
  end

  // Next-state, operand capture, HI/LO update and done generation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Start takes priority; a simultaneous MTHI/MTLO is dropped.
          cnt_d = {CNT_W{1'b0}};
          rem_d = {WIDTH{1'b0}};
          if (is_div) begin
            state_d = ST_DIV;
            acc_d   = {{WIDTH{1'b0}}, op_a};
            opb_d   = op_b;
          end else begin
            state_d = ST_MUL;
            acc_d   = {{WIDTH{1'b0}}, op_b};
            opb_d   = op_a;
          end
        end else begin
          if (wr_hi) begin
            hi_d = op_a;
          end else begin
            hi_d = hi_q;
          end
          if (wr_lo) begin
            lo_d = op_a;
          end else begin
            lo_d = lo_q;
          end
        end
      end
      ST_MUL: begin
        acc_d = mul_next_s;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_s) begin
          hi_d    = mul_next_s[2*WIDTH-1:WIDTH];
          lo_d    = mul_next_s[WIDTH-1:0];
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_MUL;
        end
      end
      ST_DIV: begin
        acc_d = {acc_q[2*WIDTH-1:WIDTH], div_quot_s};
        rem_d = div_rem_s;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_s) begin
          lo_d    = div_quot_s;
          hi_d    = div_rem_s;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DIV;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      acc_q   <= {(2*WIDTH){1'b0}};
      opb_q   <= {WIDTH{1'b0}};
      rem_q   <= {WIDTH{1'b0}};
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  // Read mux for MFHI/MFLO.
  always_comb begin
    case (lh_sel)
      2'b01:   lh_data = lo_q;
      2'b10:   lh_data = hi_q;
      default: lh_data = {WIDTH{1'b0}};
    endcase
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign done  = done_q;
  assign busy  = (state_q != ST_IDLE);
  assign stall = busy & ((lh_sel != 2'b00) | start | wr_hi | wr_lo);

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: directed cases plus randomized
// operations compared against plain-arithmetic expectations.
module tb_hilo_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_div;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [1:0]  lh_sel;
  logic        wr_hi;
  logic        wr_lo;
  logic [31:0] lh_data;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        stall;

  int          n_checks = 0;
  int          n_fails  = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  hilo_muldiv_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .is_div  (is_div),
    .op_a    (op_a),
    .op_b    (op_b),
    .lh_sel  (lh_sel),
    .wr_hi   (wr_hi),
    .wr_lo   (wr_lo),
    .lh_data (lh_data),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .done    (done),
    .stall   (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start  = 1'b0;
    is_div = 1'b0;
    op_a   = 32'd0;
    op_b   = 32'd0;
    lh_sel = 2'b00;
    wr_hi  = 1'b0;
    wr_lo  = 1'b0;
  endtask

  function automatic logic [31:0] sel_model(input logic [1:0] s, input logic [31:0] h, input logic [31:0] l);
    if (s == 2'b01) return l;
    else if (s == 2'b10) return h;
    else return 32'd0;
  endfunction

  // Issue one operation and follow it to its done cycle (returns in the done cycle).
  // With noise set, random start/write/read traffic is driven while busy.
  task automatic run_op(input logic dv, input logic [31:0] a, input logic [31:0] b,
                        input bit noise, input logic [1:0] rd);
    logic [63:0] prod;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
    logic        exp_stall;
    if (dv) begin
      if (b == 32'd0) begin
        e_lo = 32'hFFFF_FFFF;
        e_hi = a;
      end else begin
        e_lo = a / b;
        e_hi = a % b;
      end
    end else begin
      prod = 64'(a) * 64'(b);
      e_hi = prod[63:32];
      e_lo = prod[31:0];
    end
    idle_inputs();
    start  = 1'b1;
    is_div = dv;
    op_a   = a;
    op_b   = b;
    if (noise) begin
      wr_hi = 1'($urandom_range(0, 1));
      wr_lo = 1'($urandom_range(0, 1));
    end
    tick();
    for (int c = 1; c <= 32; c++) begin
      if (noise) begin
        start  = ($urandom_range(0, 3) == 0);
        is_div = 1'($urandom_range(0, 1));
        op_a   = $urandom;
        op_b   = $urandom;
        wr_hi  = ($urandom_range(0, 3) == 0);
        wr_lo  = ($urandom_range(0, 3) == 0);
        lh_sel = 2'($urandom_range(0, 3));
      end else begin
        idle_inputs();
        lh_sel = rd;
      end
      #1;
      exp_stall = (lh_sel != 2'b00) | start | wr_hi | wr_lo;
      check_val("busy_run", busy, 1'b1);
      check_val("done_run", done, 1'b0);
      check_val("hi_hold", hi, m_hi);
      check_val("lo_hold", lo, m_lo);
      check_val("stall_run", stall, exp_stall);
      check_val("lh_data_run", lh_data, sel_model(lh_sel, m_hi, m_lo));
      tick();
    end
    m_hi = e_hi;
    m_lo = e_lo;
    idle_inputs();
    lh_sel = rd;
    #1;
    check_val("busy_done", busy, 1'b0);
    check_val("done_pulse", done, 1'b1);
    check_val("hi_result", hi, m_hi);
    check_val("lo_result", lo, m_lo);
    check_val("stall_done", stall, 1'b0);
    check_val("lh_data_done", lh_data, sel_model(rd, m_hi, m_lo));
  endtask

  initial begin
    logic        dv;
    logic [31:0] a;
    logic [31:0] b;
    idle_inputs();
    rst_n = 1'b0;
    m_hi  = 32'd0;
    m_lo  = 32'd0;
    tick();
    tick();
    check_val("rst_hi", hi, 32'd0);
    check_val("rst_lo", lo, 32'd0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_done", done, 1'b0);
    rst_n = 1'b1;
    tick();

    // Max-value multiply, read HI in the done cycle.
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 2'b10);
    check_val("mul_max_hi", hi, 32'hFFFF_FFFE);
    tick();
    check_val("done_once", done, 1'b0);

    // Divide, then a back-to-back divide by zero issued in the done cycle.
    run_op(1'b1, 32'd100, 32'd7, 1'b0, 2'b01);
    check_val("div_lo", lo, 32'd14);
    run_op(1'b1, 32'h0000_1234, 32'd0, 1'b0, 2'b01);
    check_val("div0_lo", lo, 32'hFFFF_FFFF);
    check_val("div0_hi", hi, 32'h0000_1234);

    // Multiply with random interference (start/writes) while busy.
    run_op(1'b0, 32'd3, 32'd5, 1'b1, 2'b00);
    check_val("mul35_lo", lo, 32'd15);

    // MTHI in idle, then MTLO traffic during a multiply.
    idle_inputs();
    op_a  = 32'hDEAD_BEEF;
    wr_hi = 1'b1;
    tick();
    m_hi = 32'hDEAD_BEEF;
    idle_inputs();
    #1;
    check_val("mthi", hi, 32'hDEAD_BEEF);
    idle_inputs();
    op_a  = 32'h1357_9BDF;
    wr_lo = 1'b1;
    tick();
    m_lo = 32'h1357_9BDF;
    check_val("mtlo", lo, 32'h1357_9BDF);
    run_op(1'b0, 32'd1000, 32'd1000, 1'b1, 2'b01);

    // Start and write together: start wins.
    idle_inputs();
    tick();
    run_op(1'b0, 32'd7, 32'd6, 1'b1, 2'b10);

    // Reset mid-divide aborts immediately.
    idle_inputs();
    start  = 1'b1;
    is_div = 1'b1;
    op_a   = 32'd1000;
    op_b   = 32'd3;
    tick();
    idle_inputs();
    for (int i = 0; i < 9; i++) tick();
    rst_n = 1'b0;
    #1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    check_val("arst_hi", hi, 32'd0);
    check_val("arst_lo", lo, 32'd0);
    check_val("arst_busy", busy, 1'b0);
    check_val("arst_done", done, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    run_op(1'b0, 32'd2, 32'd2, 1'b0, 2'b01);
    check_val("post_rst_lo", lo, 32'd4);

    // Randomized operations.
    for (int k = 0; k < 24; k++) begin
      dv = 1'($urandom_range(0, 1));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 255));
        default: b = $urandom;
      endcase
      run_op(dv, a, b, ($urandom_range(0, 1) == 1), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1) begin
        idle_inputs();
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
